// File: rtl/opb_cmd_pkg.sv
// Shared constants for the OPB command FIFO slave: register offsets and
// the bit layout of the STATUS and CTRL registers.
package opb_cmd_pkg;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;
   localparam logic [1:0] REG_DROPS  = 2'd3;

   localparam int ST_COUNT_W = 9;
   localparam int ST_FULL    = 16;
   localparam int ST_EMPTY   = 17;
   localparam int ST_OVF     = 24;

   localparam int CTRL_FLUSH   = 0;
   localparam int CTRL_CLR_OVF = 1;

   // Transfer captured in the address-phase cycle, replayed at the ack edge.
   typedef struct packed {
      logic [1:0]  ofs;
      logic        rnw;
      logic [31:0] wdata;
   } opb_req_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO: head word is read combinationally at the
// read pointer. A push into a full FIFO is accepted only alongside a pop.
module sync_fifo_fwft #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   input  logic             flush_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o,
   output logic             drop_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign drop_o  = push_i & full_o & ~do_pop;
   assign dout_o  = mem_q[rptr_q];
   assign count_o = count_q;

   // Flush dominates any pop or push landing on the same edge.
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (flush_i) begin
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) wptr_d = wptr_q + 1'b1;
         if (do_pop)  rptr_d = rptr_q + 1'b1;
         count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wptr_q] <= din_i;
   end

endmodule

// File: rtl/opb_cmd_fifo_slave.sv
// OPB slave that queues software-written command words into a FWFT FIFO
// drained by fabric logic; exposes status, flush/overflow-clear and a drop count.
module opb_cmd_fifo_slave
   import opb_cmd_pkg::*;
#(
   parameter logic [31:0] C_BASEADDR   = 32'h01001200,
   parameter logic [31:0] C_HIGHADDR   = 32'h010012FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter int          C_FIFO_DEPTH = 16,
   parameter string       C_FAMILY     = "virtex5"
) (
   input  logic                    OPB_Clk,
   input  logic                    OPB_Rst,
   input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
   input  logic [0:3]              OPB_BE,
   input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
   input  logic                    OPB_RNW,
   input  logic                    OPB_select,
   input  logic                    OPB_seqAddr,
   output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
   output logic                    Sl_errAck,
   output logic                    Sl_retry,
   output logic                    Sl_toutSup,
   output logic                    Sl_xferAck,
   output logic [31:0]             user_data_out,
   output logic                    user_valid,
   input  logic                    user_ready
);

   localparam int AW = $clog2(C_FIFO_DEPTH);

   logic          hit, ack_d, ack_q;
   opb_req_t      req_d, req_q;
   logic [31:0]   dbus_d, dbus_q, rdata;
   logic [31:0]   status;
   logic          wr_commit, push, ctrl_wr, flush, clr_ovf;
   logic          ovf_d, ovf_q;
   logic [15:0]   drops_d, drops_q;
   logic [AW:0]   fifo_count;
   logic          fifo_full, fifo_empty, fifo_drop;
   logic          unused_ok;

   assign unused_ok = ^{OPB_seqAddr, OPB_BE, (C_FAMILY == "")};

   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;
   assign Sl_xferAck = ack_q;
   assign Sl_DBus    = dbus_q;
   assign user_valid = ~fifo_empty;

   assign hit   = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   // Blocking a hit while ack is high prevents a second ack on a held select.
   assign ack_d = hit & ~ack_q;
   assign req_d = ack_d ? '{ofs: OPB_ABus[28:29], rnw: OPB_RNW, wdata: OPB_DBus} : req_q;

   always_comb begin
      status                     = '0;
      status[ST_COUNT_W-1:0]     = ST_COUNT_W'(fifo_count);
      status[ST_FULL]            = fifo_full;
      status[ST_EMPTY]           = fifo_empty;
      status[ST_OVF]             = ovf_q;
      unique case (OPB_ABus[28:29])
         REG_STATUS: rdata = status;
         REG_DROPS:  rdata = {16'h0, drops_q};
         default:    rdata = '0;
      endcase
   end

   assign dbus_d = (ack_d && OPB_RNW) ? rdata : '0;

   // Writes take effect on the edge that ends the ack cycle.
   assign wr_commit = ack_q & ~req_q.rnw;
   assign push      = wr_commit & (req_q.ofs == REG_DATA);
   assign ctrl_wr   = wr_commit & (req_q.ofs == REG_CTRL);
   assign flush     = ctrl_wr & req_q.wdata[CTRL_FLUSH];
   assign clr_ovf   = ctrl_wr & req_q.wdata[CTRL_CLR_OVF];

   always_comb begin
      ovf_d   = ovf_q;
      drops_d = drops_q;
      if (clr_ovf) begin
         ovf_d   = 1'b0;
         drops_d = '0;
      end else if (fifo_drop) begin
         ovf_d = 1'b1;
         if (drops_q != 16'hFFFF) drops_d = drops_q + 16'd1;
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         ack_q   <= 1'b0;
         dbus_q  <= '0;
         req_q   <= '0;
         ovf_q   <= 1'b0;
         drops_q <= '0;
      end else begin
         ack_q   <= ack_d;
         dbus_q  <= dbus_d;
         req_q   <= req_d;
         ovf_q   <= ovf_d;
         drops_q <= drops_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (32),
      .DEPTH (C_FIFO_DEPTH)
   ) u_fifo (
      .clk     (OPB_Clk),
      .rst     (OPB_Rst),
      .push_i  (push),
      .din_i   (req_q.wdata),
      .pop_i   (user_ready & user_valid),
      .flush_i (flush),
      .dout_o  (user_data_out),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .drop_o  (fifo_drop)
   );

endmodule
